// File: rtl/game_pkg.sv
// game_pkg: category indices, edge-bit positions and detector state shared by the collision logic
package game_pkg;
  localparam int N_CAT = 4;
  localparam int CAT_ROPE = 0;
  localparam int CAT_FRUIT = 1;
  localparam int CAT_ENEMY = 2;
  localparam int CAT_BORDER = 3;
  localparam int EDGE_LEFT = 0;
  localparam int EDGE_TOP = 1;
  localparam int EDGE_RIGHT = 2;
  localparam int EDGE_BOTTOM = 3;
  typedef enum logic {WAIT_SOF, ACTIVE} det_state_t;
endpackage

// File: rtl/overlap_qualifier.sv
// overlap_qualifier: per-frame saturating overlap counter that fires a single registered pulse at threshold
module overlap_qualifier #(
  parameter int MIN_OVERLAP_PIXELS = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  input  logic hit,
  output logic pulse,
  output logic fired
);
  localparam logic [CNT_W-1:0] MIN = CNT_W'(MIN_OVERLAP_PIXELS);
  logic [CNT_W-1:0] cnt, base_cnt, nxt_cnt;
  logic base_fired, step, reach;
  // a clear coincident with a hit restarts the frame and counts that hit as its first pixel
  always_comb begin
    base_cnt = clear ? '0 : cnt;
    base_fired = clear ? 1'b0 : fired;
    step = enable & hit & (base_cnt < MIN);
    nxt_cnt = base_cnt + CNT_W'(step);
    reach = step & (nxt_cnt == MIN);
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      cnt <= '0;
      fired <= 1'b0;
      pulse <= 1'b0;
    end else begin
      cnt <= nxt_cnt;
      fired <= base_fired | reach;
      pulse <= reach & ~base_fired;
    end
endmodule

// File: rtl/player_collision_detector.sv
// player_collision_detector: qualifies player overlaps per frame into hit pulses and a latched frame summary
module player_collision_detector
  import game_pkg::*;
#(
  parameter int MIN_OVERLAP_PIXELS = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       playerDrawRequest,
  input  logic       ropeDrawRequest,
  input  logic       fruitDrawRequest,
  input  logic [3:0] HitEdgeCode,
  input  logic       enemyDrawRequest,
  input  logic       borderDrawRequest,
  output logic       ropeHit,
  output logic       fruitHit,
  output logic       enemyHit,
  output logic       borderHit,
  output logic [3:0] frameSummary,
  output logic [3:0] ropeEdgeSummary,
  output logic       summaryValid
);
  det_state_t state, state_nxt;
  logic active, clear;
  logic [N_CAT-1:0] req, ov, pulse, fired;
  logic [3:0] rope_code, edge_acc;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= WAIT_SOF;
    else state <= state_nxt;
  always_comb state_nxt = (state == WAIT_SOF && startOfFrame) ? ACTIVE : state;
  always_comb begin
    active = state == ACTIVE;
    clear = active & startOfFrame;
  end
  assign req = {borderDrawRequest, enemyDrawRequest, fruitDrawRequest, ropeDrawRequest};
  assign ov = {N_CAT{playerDrawRequest}} & req;
  assign rope_code = ov[CAT_ROPE] ? HitEdgeCode : 4'b0;
  for (genvar g = 0; g < N_CAT; g++) begin : g_cat
    overlap_qualifier #(.MIN_OVERLAP_PIXELS(MIN_OVERLAP_PIXELS), .CNT_W(CNT_W)) u_q (
      .clk(clk),
      .resetN(resetN),
      .clear(clear),
      .enable(active),
      .hit(ov[g]),
      .pulse(pulse[g]),
      .fired(fired[g])
    );
  end
  assign ropeHit = pulse[CAT_ROPE];
  assign fruitHit = pulse[CAT_FRUIT];
  assign enemyHit = pulse[CAT_ENEMY];
  assign borderHit = pulse[CAT_BORDER];
  // the summary captures the old frame's flags; edge_acc restarts with any coincident rope overlap
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      edge_acc <= '0;
      frameSummary <= '0;
      ropeEdgeSummary <= '0;
      summaryValid <= 1'b0;
    end else begin
      edge_acc <= clear ? rope_code : active ? (edge_acc | rope_code) : edge_acc;
      if (clear) begin
        frameSummary <= fired;
        ropeEdgeSummary <= edge_acc;
        summaryValid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_player_collision_detector.sv
// tb_player_collision_detector: scoreboard bench driving MIN=4 and MIN=1 detectors against a frame-level model
module tb_player_collision_detector;
  logic clk = 0, resetN = 0, sof = 0, pdr = 0, rdr = 0, fdr = 0, edr = 0, bdr = 0;
  logic [3:0] code = 0;
  logic [3:0] hit_a, fs_a, es_a, hit_b, fs_b, es_b;
  logic sv_a, sv_b;
  logic [12:0] obs_a, obs_b;
  logic [12:0] q_a[$], q_b[$];
  int compared = 0, mismatched = 0;
  int mn[2] = '{4, 1};
  bit act[2];
  int cnt[2][4];
  bit fired[2][4];
  logic [3:0] eacc[2], summ[2], esum[2], pul[2];
  bit valid[2];
  always #5 clk = ~clk;
  player_collision_detector #(.MIN_OVERLAP_PIXELS(4), .CNT_W(8)) dut_a (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .playerDrawRequest(pdr),
    .ropeDrawRequest(rdr), .fruitDrawRequest(fdr), .HitEdgeCode(code),
    .enemyDrawRequest(edr), .borderDrawRequest(bdr),
    .ropeHit(hit_a[0]), .fruitHit(hit_a[1]), .enemyHit(hit_a[2]), .borderHit(hit_a[3]),
    .frameSummary(fs_a), .ropeEdgeSummary(es_a), .summaryValid(sv_a));
  player_collision_detector #(.MIN_OVERLAP_PIXELS(1), .CNT_W(8)) dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .playerDrawRequest(pdr),
    .ropeDrawRequest(rdr), .fruitDrawRequest(fdr), .HitEdgeCode(code),
    .enemyDrawRequest(edr), .borderDrawRequest(bdr),
    .ropeHit(hit_b[0]), .fruitHit(hit_b[1]), .enemyHit(hit_b[2]), .borderHit(hit_b[3]),
    .frameSummary(fs_b), .ropeEdgeSummary(es_b), .summaryValid(sv_b));
  assign obs_a = {hit_a, fs_a, es_a, sv_a};
  assign obs_b = {hit_b, fs_b, es_b, sv_b};
  task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s @%0t: got hits=%b summary=%b edges=%b valid=%b, want hits=%b summary=%b edges=%b valid=%b",
               name, $time, got[12:9], got[8:5], got[4:1], got[0], want[12:9], want[8:5], want[4:1], want[0]);
    end
  endtask
  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      act[m] = 0; eacc[m] = 0; summ[m] = 0; esum[m] = 0; pul[m] = 0; valid[m] = 0;
      for (int c = 0; c < 4; c++) begin cnt[m][c] = 0; fired[m][c] = 0; end
    end
  endtask
  task automatic model_step(input int m, output logic [12:0] exp);
    bit ov[4];
    ov[0] = pdr & rdr; ov[1] = pdr & fdr; ov[2] = pdr & edr; ov[3] = pdr & bdr;
    pul[m] = 0;
    if (!act[m]) act[m] = sof;
    else begin
      if (sof) begin
        for (int c = 0; c < 4; c++) summ[m][c] = fired[m][c];
        esum[m] = eacc[m]; valid[m] = 1; eacc[m] = 0;
        for (int c = 0; c < 4; c++) begin cnt[m][c] = 0; fired[m][c] = 0; end
      end
      for (int c = 0; c < 4; c++)
        if (ov[c] && cnt[m][c] < mn[m]) begin
          cnt[m][c]++;
          if (cnt[m][c] == mn[m] && !fired[m][c]) begin pul[m][c] = 1; fired[m][c] = 1; end
        end
      if (ov[0]) eacc[m] |= code;
    end
    exp = {pul[m], summ[m], esum[m], valid[m]};
  endtask
  task automatic cycle(input bit s, input bit p, input bit r, input bit f, input bit e, input bit b, input logic [3:0] k);
    logic [12:0] ea, eb;
    sof = s; pdr = p; rdr = r; fdr = f; edr = e; bdr = b; code = k;
    model_step(0, ea); q_a.push_back(ea);
    model_step(1, eb); q_b.push_back(eb);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 4'h0);
  endtask
  task automatic do_reset();
    resetN = 0;
    #1;
    check("reset_a", obs_a, 13'h0);
    check("reset_b", obs_b, 13'h0);
    sof = 0; pdr = 0; rdr = 0; fdr = 0; edr = 0; bdr = 0; code = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetN = 1;
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (q_a.size() > 0) check("min4", obs_a, q_a.pop_front());
    if (q_b.size() > 0) check("min1", obs_b, q_b.pop_front());
  end
  initial begin
    model_reset();
    #1;
    check("por_a", obs_a, 13'h0);
    check("por_b", obs_b, 13'h0);
    @(negedge clk);
    resetN = 1;
    // overlaps before the first frame start are ignored
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 1, 1, 1, 4'hF);
    idle(2);
    cycle(1, 0, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0, 0, 4'h0);
    idle(3);
    cycle(1, 0, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 1, 0, 0, 4'h0);
    idle(2);
    cycle(1, 0, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, 0, 0, 4'h0);
    idle(2);
    cycle(1, 0, 0, 0, 0, 0, 4'h0);
    cycle(0, 1, 1, 0, 0, 0, 4'b0001);
    cycle(0, 1, 1, 0, 0, 0, 4'b1000);
    cycle(0, 1, 0, 1, 0, 0, 4'b0100);
    cycle(0, 0, 1, 0, 0, 0, 4'b0010);
    idle(2);
    cycle(1, 1, 0, 0, 1, 0, 4'h0);
    idle(2);
    cycle(0, 1, 0, 0, 1, 1, 4'h0);
    idle(2);
    // threshold-reaching overlap coincident with frame start belongs to the new frame
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0, 4'h0);
    cycle(1, 1, 1, 0, 0, 0, 4'h0);
    idle(2);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0, 4'h0);
    do_reset();
    cycle(1, 0, 0, 0, 0, 0, 4'h0);
    cycle(0, 1, 1, 0, 0, 0, 4'h0);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 7) == 0,
            4'($urandom_range(0, 15)));
    end
    idle(2);
    @(negedge clk);
    compared++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", q_a.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
